// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared image-geometry defaults for the 3x3 matrix path.
//   PIX_WIDTH  : pixel bit width (matches the line buffers)
//   IMG_WIDTH  : pixels per line
//   IMG_HEIGHT : lines per frame
//   CW / RW    : column / row counter widths, sized so 2^CW > IMG_WIDTH
//                and 2^RW > IMG_HEIGHT
//   LAST_COL   : last column index of a line
//   LAST_ROW   : last aligned-line index (top row of the last full window)
// -----------------------------------------------------------------------------
package img_pkg;

    localparam int PIX_WIDTH  = 10;
    localparam int IMG_WIDTH  = 480;
    localparam int IMG_HEIGHT = 272;

    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);

    localparam int LAST_COL = IMG_WIDTH - 1;
    // Only IMG_HEIGHT-2 aligned lines exist: the first two raw lines merely
    // fill the line buffers.
    localparam int LAST_ROW = IMG_HEIGHT - 3;

endpackage

// File: rtl/win_shift3.sv
// -----------------------------------------------------------------------------
// win_shift3
// 3-tap enable-gated shift register, one per window row.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (taps cleared)
//   en_i       : shift when high, hold otherwise
//   din_i      : newest pixel, enters tap 2
//   q_o        : q_o[0] = oldest (left), q_o[2] = newest (right)
// -----------------------------------------------------------------------------
module win_shift3 #(
    parameter int WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [WIDTH-1:0]          din_i,
    output logic [2:0][WIDTH-1:0]     q_o
);

    logic [2:0][WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= {din_i, q_q[2], q_q[1]};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/window_3x3_gen.sv
// -----------------------------------------------------------------------------
// window_3x3_gen
// Builds a registered 3x3 pixel window from three vertically aligned taps and
// flags only windows lying fully inside the image.
// Optional feature macro: WIN_COORD_EN (adds out_x / out_y centre coordinates).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   row0_in             : bottom (newest) row pixel
//   row1_in             : middle row pixel (first line-buffer stage)
//   row2_in             : top (oldest) row pixel (second line-buffer stage)
//   valid_in            : taps aligned and valid; everything holds when low
//   m11..m33            : window, row-major, m22 = centre
//   valid_out           : window complete and inside the image
//   frame_done          : pulse with the last valid window of a frame
//   out_x, out_y        : centre column/row (WIN_COORD_EN only)
// -----------------------------------------------------------------------------
module window_3x3_gen #(
    parameter int WIDTH      = img_pkg::PIX_WIDTH,
    parameter int IMG_WIDTH  = img_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = img_pkg::IMG_HEIGHT,
    parameter int CW         = $clog2(IMG_WIDTH + 1),
    parameter int RW         = $clog2(IMG_HEIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] row0_in,
    input  logic [WIDTH-1:0] row1_in,
    input  logic [WIDTH-1:0] row2_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] m11,
    output logic [WIDTH-1:0] m12,
    output logic [WIDTH-1:0] m13,
    output logic [WIDTH-1:0] m21,
    output logic [WIDTH-1:0] m22,
    output logic [WIDTH-1:0] m23,
    output logic [WIDTH-1:0] m31,
    output logic [WIDTH-1:0] m32,
    output logic [WIDTH-1:0] m33,
    output logic             valid_out,
    output logic             frame_done
`ifdef WIN_COORD_EN
    ,
    output logic [CW-1:0]    out_x,
    output logic [RW-1:0]    out_y
`endif
);

    import img_pkg::*;

    localparam logic [CW-1:0] LAST_COL_C = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW_C = RW'(IMG_HEIGHT - 3);

    // ---------------------------------------------------------------- window
    // Row index 0 = top (row2_in), 2 = bottom (row0_in).
    logic [2:0][WIDTH-1:0]        row_din;
    logic [2:0][2:0][WIDTH-1:0]   taps;

    assign row_din[0] = row2_in;
    assign row_din[1] = row1_in;
    assign row_din[2] = row0_in;

    for (genvar r = 0; r < 3; r++) begin : g_row
        win_shift3 #(.WIDTH(WIDTH)) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (valid_in),
            .din_i (row_din[r]),
            .q_o   (taps[r])
        );
    end

    assign m11 = taps[0][0];
    assign m12 = taps[0][1];
    assign m13 = taps[0][2];
    assign m21 = taps[1][0];
    assign m22 = taps[1][1];
    assign m23 = taps[1][2];
    assign m31 = taps[2][0];
    assign m32 = taps[2][1];
    assign m33 = taps[2][2];

    // -------------------------------------------------------------- position
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          eol;

    assign eol = (col_q == LAST_COL_C);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (eol) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW_C) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // col_q is the column being loaded by this beat; columns 0 and 1 would
    // give a window straddling the previous line, so they are suppressed.
    logic valid_d, done_d;
    logic valid_q, done_q;

    assign valid_d = valid_in && (col_q >= CW'(2));
    assign done_d  = valid_in && eol && (row_q == LAST_ROW_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign valid_out  = valid_q;
    assign frame_done = done_q;

`ifdef WIN_COORD_EN
    // Centre of the window loaded by this beat: one column back, one row
    // below the top tap. Updated only with a valid window so the pair holds
    // whenever valid_out is low.
    logic [CW-1:0] x_q;
    logic [RW-1:0] y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (valid_d) begin
            x_q <= col_q - CW'(1);
            y_q <= row_q + RW'(1);
        end
    end

    assign out_x = x_q;
    assign out_y = y_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_window_3x3_gen
// Self-checking bench for window_3x3_gen on an 8x6 image. A reference model
// derives each beat's aligned line / column from the running beat count and
// keeps the window as the last three accepted tap columns.
// -----------------------------------------------------------------------------
module tb_window_3x3_gen;

    localparam int W  = 10;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int CW = 4;
    localparam int RW = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] row0_in = '0, row1_in = '0, row2_in = '0;
    logic         valid_in = 1'b0;
    logic [W-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
    logic         valid_out, frame_done;
`ifdef WIN_COORD_EN
    logic [CW-1:0] out_x;
    logic [RW-1:0] out_y;
`endif

    always #5 clk = ~clk;

    window_3x3_gen #(
        .WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .CW(CW), .RW(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .row0_in(row0_in), .row1_in(row1_in), .row2_in(row2_in),
        .valid_in(valid_in),
        .m11(m11), .m12(m12), .m13(m13),
        .m21(m21), .m22(m22), .m23(m23),
        .m31(m31), .m32(m32), .m33(m33),
        .valid_out(valid_out), .frame_done(frame_done)
`ifdef WIN_COORD_EN
        , .out_x(out_x), .out_y(out_y)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------ ref model
    logic [W-1:0] img [IH][IW];
    logic [W-1:0] win [3][3];   // [row top..bottom][col left..right]
    int           kbeat;
    int           nvo;
    int           ex, ey;

    function automatic logic [127:0] win_vec();
        return {win[0][0], win[0][1], win[0][2],
                win[1][0], win[1][1], win[1][2],
                win[2][0], win[2][1], win[2][2]};
    endfunction

    function automatic logic [127:0] dut_vec();
        return {m11, m12, m13, m21, m22, m23, m31, m32, m33};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++) win[r][j] = '0;
        kbeat = 0;
        ex = 0;
        ey = 0;
    endtask

    // One clock: drive taps for the next beat (or a gap), then check.
    task automatic step(input bit v);
        int  c, L;
        bit  e_vo, e_fd;
        c = kbeat % IW;
        L = (kbeat / IW) % (IH - 2);
        @(negedge clk);
        valid_in = v;
        row2_in  = img[L][c];
        row1_in  = img[L+1][c];
        row0_in  = img[L+2][c];
        @(posedge clk);
        #1;
        e_vo = 1'b0;
        e_fd = 1'b0;
        if (v) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] = win[r][1];
                win[r][1] = win[r][2];
                win[r][2] = img[L+r][c];
            end
            e_vo = (c >= 2);
            e_fd = (c == IW-1) && (L == IH-3);
            if (e_vo) begin
                ex = c - 1;
                ey = L + 1;
                nvo++;
            end
            kbeat++;
        end
        chk("valid_out", valid_out, e_vo);
        chk("frame_done", frame_done, e_fd);
        chk("window", dut_vec(), win_vec());
`ifdef WIN_COORD_EN
        chk("out_x", out_x, ex);
        chk("out_y", out_y, ey);
`endif
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        int           gap;
        int           nb;
        bit           vo;
        bit           fd;
        logic [W-1:0] e11, e13, e22, e33;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{0, 2,  1'b0, 1'b0, 10'h00, 10'h01, 10'h10, 10'h21};
        tbl[1]  = '{0, 1,  1'b1, 1'b0, 10'h00, 10'h02, 10'h11, 10'h22};
        tbl[2]  = '{0, 5,  1'b1, 1'b0, 10'h05, 10'h07, 10'h16, 10'h27};
        tbl[3]  = '{0, 1,  1'b0, 1'b0, 10'h06, 10'h10, 10'h17, 10'h30};
        tbl[4]  = '{0, 1,  1'b0, 1'b0, 10'h07, 10'h11, 10'h20, 10'h31};
        tbl[5]  = '{0, 1,  1'b1, 1'b0, 10'h10, 10'h12, 10'h21, 10'h32};
        tbl[6]  = '{0, 2,  1'b1, 1'b0, 10'h12, 10'h14, 10'h23, 10'h34};
        tbl[7]  = '{3, 0,  1'b0, 1'b0, 10'h12, 10'h14, 10'h23, 10'h34};
        tbl[8]  = '{0, 1,  1'b1, 1'b0, 10'h13, 10'h15, 10'h24, 10'h35};
        tbl[9]  = '{0, 18, 1'b1, 1'b1, 10'h35, 10'h37, 10'h46, 10'h57};
        tbl[10] = '{0, 1,  1'b0, 1'b0, 10'h36, 10'h00, 10'h47, 10'h20};
        tbl[11] = '{0, 2,  1'b1, 1'b0, 10'h00, 10'h02, 10'h11, 10'h22};

        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) img[y][x] = W'(y*16 + x);
        model_reset();
        nvo = 0;

        // Reset state
        #3;
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_window", dut_vec(), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Deterministic stream: line boundary, gap at x=4, frame wrap
        for (int i = 0; i < 12; i++) begin
            repeat (tbl[i].gap) step(1'b0);
            repeat (tbl[i].nb)  step(1'b1);
            chk($sformatf("tbl%0d_valid_out", i), valid_out, tbl[i].vo);
            chk($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].fd);
            chk($sformatf("tbl%0d_m11", i), m11, tbl[i].e11);
            chk($sformatf("tbl%0d_m13", i), m13, tbl[i].e13);
            chk($sformatf("tbl%0d_m22", i), m22, tbl[i].e22);
            chk($sformatf("tbl%0d_m33", i), m33, tbl[i].e33);
            if (i == 9) chk("frame_window_count", nvo, 24);
`ifdef WIN_COORD_EN
            if (i == 1) begin
                chk("first_out_x", out_x, 1);
                chk("first_out_y", out_y, 1);
            end
            if (i == 9) begin
                chk("last_out_x", out_x, 6);
                chk("last_out_y", out_y, 4);
            end
`endif
        end

        // Asynchronous reset mid-line at x=5
        repeat (3) step(1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_out", valid_out, 1'b0);
        chk("async_rst_frame_done", frame_done, 1'b0);
        chk("async_rst_window", dut_vec(), 128'd0);
`ifdef WIN_COORD_EN
        chk("async_rst_out_x", out_x, 0);
        chk("async_rst_out_y", out_y, 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b1);
        chk("post_rst_beat2_valid_out", valid_out, 1'b0);
        step(1'b1);
        chk("post_rst_beat3_valid_out", valid_out, 1'b1);
        chk("post_rst_m11", m11, 10'h00);
        chk("post_rst_m33", m33, 10'h22);

        // Randomised pixels and valid gaps across several frames
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) img[y][x] = W'($urandom);
        for (int n = 0; n < 400; n++) step($urandom_range(0, 3) != 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
